div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle controller for DIV/DIVU in the EX stage.
- Captures the ID-generated operand_1 (dividend) and operand_2 (divisor), then runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline via stall_req until the result is ready, then presents quotient (LO) and remainder (HI) for write into the HI/LO registers.
- Exception or branch flush aborts an in-flight division.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two).
- CNT_W, 5, iteration counter width; equals log2(WIDTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX holds a DIV/DIVU instruction; sampled only in IDLE.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- operand_1  in  WIDTH  dividend; sampled with start.
- operand_2  in  WIDTH  divisor; sampled with start.
- flush  in  1  pipeline flush; aborts any operation.
- stall_req  out  1  request to stall IF/ID/EX.
- done  out  1  one-cycle pulse; result valid.
- quotient  out  WIDTH  LO result, valid when done=1.
- remainder  out  WIDTH  HI result, valid when done=1.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, counter=0, internal regs=0, done=0, quotient=0, remainder=0. stall_req=0 combinationally in IDLE with start=0.
- States: IDLE, DIVZERO, BUSY, DONE (2-bit encoding).
- IDLE:
  - start=1 and flush=0: latch |operands| (signed) or raw operands (unsigned), latch sign flags.
  - Next state is DIVZERO if operand_2==0, else BUSY with counter=0.
  - stall_req=start (combinational), so the issuing instruction is held in its start cycle.
- BUSY:
  - Per cycle: partial remainder = {rem[WIDTH-2:0], dividend MSB}.
  - If it is >= divisor: subtract and shift 1 into the quotient; else shift 0.
  - Counter increments; after counter==WIDTH-1 completes, go to DONE.
  - stall_req=1.
- DIVZERO: stall_req=1; force quotient=0, remainder=0; go to DONE next cycle.
- DONE:
  - done=1 for exactly one cycle; stall_req=0 so the instruction advances.
  - Outputs hold their value until the next start; next state IDLE.
  - start in DONE is ignored.
- Sign fix-up, applied entering DONE, signed only:
  - quotient negated if dividend and divisor signs differ.
  - remainder takes the dividend's sign.
- Latency: start at cycle 0 gives done at cycle WIDTH+1 (33); divide-by-zero gives done at cycle 2.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives quotient=0x80000000, remainder=0. This falls out of the unsigned core with fix-up; no special case.
- flush:
  - In any state, next state is IDLE; done is not asserted and outputs are not updated. stall_req=0 in the same cycle.
  - flush has priority over start and over BUSY completion.
- start while BUSY/DIVZERO: ignored, operands not re-sampled.
- rst mid-operation: immediate return to reset values at the next edge; no done.
- Width rules: all arithmetic on WIDTH+1 bits for the compare/subtract. Negation is two's complement modulo 2^WIDTH.

Decomposition:
- Shared bus.v gets a DIV_STATE_BUS define plus DIV_IDLE, DIV_ZERO, DIV_BUSY, DIV_DONE state constants.
- One natural sub-module: div_core_step, a combinational single-iteration shift/compare/subtract (rem, dividend bit, divisor in; next rem, quotient bit out). The FSM, counter and sign handling stay in div_sequencer.

Test Plan:
- DIVU 100/7, start at cycle 0: stall_req=1 cycles 0–32; done=1 at cycle 33 with quotient=14, remainder=2; stall_req=0 at cycle 33.
- DIV -7/2 (0xFFFFFFF9/0x00000002): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF at done. DIV 7/-2 gives quotient=0xFFFFFFFD, remainder=1.
- DIV 5/0: done=1 at cycle 2, quotient=0, remainder=0; stall_req high cycles 0–1 only.
- DIV 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0 at cycle 33.
- DIVU 1000/3, flush=1 at cycle 10: state IDLE at cycle 11, stall_req=0 from cycle 10, no done pulse. A new start at cycle 12 (DIVU 9/4) gives done at cycle 45 with quotient=2, remainder=1.
- Back-to-back: start held through done at cycle 33 (ignored). New start at cycle 34 (DIVU 0xFFFFFFFF/1) gives done at cycle 67 with quotient=0xFFFFFFFF, remainder=0. rst=1 at cycle 50 instead gives all outputs 0 at cycle 51 and no done.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared constants and state encoding for the multi-cycle DIV/DIVU sequencer.
package div_sequencer_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_BUSY = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage divide request/response bundle between the pipeline and the sequencer.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = div_sequencer_pkg::DIV_WIDTH
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             flush;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, operand_1, operand_2, flush,
    input  stall_req, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, operand_1, operand_2, flush,
    output stall_req, done, quotient, remainder
  );
endinterface

// File: rtl/div_sequencer_core_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_sequencer_core_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Partial remainder is kept one bit wider so divisors with the MSB set still compare correctly.
  always_comb begin
    partial    = {rem, dvd_bit};
    diff       = partial - {1'b0, divisor};
    q_bit_c    = ~diff[WIDTH];
    rem_next_c = q_bit_c ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end
endmodule

// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU controller: holds the pipeline while iterating, then presents HI/LO.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd, dsr, rem, quo;
  logic             neg_q, neg_r;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             stall_c;
  logic [WIDTH-1:0] rem_next_c;
  logic             q_bit_c;
  logic [WIDTH-1:0] q_fin_c, mag_1_c, mag_2_c;
  logic             last_c;

  div_sequencer_core_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem),
    .dvd_bit    (dvd[WIDTH-1]),
    .divisor    (dsr),
    .rem_next_c (rem_next_c),
    .q_bit_c    (q_bit_c)
  );

  always_comb begin
    q_fin_c = {quo[WIDTH-2:0], q_bit_c};
    last_c  = (cnt == LAST_CNT);
    mag_1_c = (bus.signed_div && bus.operand_1[WIDTH-1]) ? -bus.operand_1 : bus.operand_1;
    mag_2_c = (bus.signed_div && bus.operand_2[WIDTH-1]) ? -bus.operand_2 : bus.operand_2;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // Stall covers the issuing cycle and every working cycle; flush releases it immediately.
  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    case (state)
      DIV_IDLE: begin
        stall_c = bus.start;
        if (bus.start) state_next = (bus.operand_2 == '0) ? DIV_ZERO : DIV_BUSY;
      end
      DIV_ZERO: begin
        stall_c    = 1'b1;
        state_next = DIV_DONE;
      end
      DIV_BUSY: begin
        stall_c = 1'b1;
        if (last_c) state_next = DIV_DONE;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (bus.flush) begin
      state_next = DIV_IDLE;
      stall_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      quo         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!bus.flush) begin
        case (state)
          DIV_IDLE: if (bus.start) begin
            dvd   <= mag_1_c;
            dsr   <= mag_2_c;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            neg_q <= bus.signed_div & (bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1]);
            neg_r <= bus.signed_div & bus.operand_1[WIDTH-1];
          end
          DIV_BUSY: begin
            rem <= rem_next_c;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            quo <= q_fin_c;
            cnt <= cnt + CNT_W'(1);
            // Sign fix-up on the final iteration; the unsigned core covers the overflow case.
            if (last_c) begin
              quotient_q  <= neg_q ? -q_fin_c : q_fin_c;
              remainder_q <= neg_r ? -rem_next_c : rem_next_c;
              done_q      <= 1'b1;
            end
          end
          DIV_ZERO: begin
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.stall_req = stall_c;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random operands vs an arithmetic model.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts an operation at the current cycle (cycle 0); optional flush or reset at abort_cyc.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int abort_cyc, input bit abort_rst);
    logic [31:0] eq, er;
    int lat, last;
    model(s, a, b, eq, er);
    lat  = (b == 32'd0) ? 2 : 33;
    last = (abort_cyc > 0) ? abort_cyc + 1 : lat;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.operand_1  = a;
    bus.operand_2  = b;
    @(negedge clk);
    check("stall_c0", 32'(bus.stall_req), 32'd1);
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(posedge clk);
      #1;
      bus.start      = hold;
      bus.operand_1  = $urandom;
      bus.operand_2  = $urandom;
      bus.signed_div = 1'($urandom);
      bus.flush      = (cyc == abort_cyc) && !abort_rst;
      rst            = (cyc == abort_cyc) && abort_rst;
      @(negedge clk);
      if (abort_cyc > 0 && cyc >= abort_cyc) begin
        check("abort_done", 32'(bus.done), 32'd0);
        if (cyc > abort_cyc || !abort_rst) check("abort_stall", 32'(bus.stall_req), 32'd0);
        if (abort_rst && cyc > abort_cyc) begin
          check("rst_quo", bus.quotient, 32'd0);
          check("rst_rem", bus.remainder, 32'd0);
        end
      end else begin
        check("stall", 32'(bus.stall_req), (cyc < lat) ? 32'd1 : 32'd0);
        check("done", 32'(bus.done), (cyc == lat) ? 32'd1 : 32'd0);
        if (cyc == lat) begin
          check("quotient", bus.quotient, eq);
          check("remainder", bus.remainder, er);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    bit          s;
    int          mode;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.operand_1  = '0;
    bus.operand_2  = '0;
    bus.flush      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);
    run_div(1'b1, 32'd5, 32'd0, 1'b0, 0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_div(1'b0, 32'd1000, 32'd3, 1'b0, 10, 1'b0);
    run_div(1'b0, 32'd9, 32'd4, 1'b0, 0, 1'b0);
    run_div(1'b0, 32'd100, 32'd7, 1'b1, 0, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
    run_div(1'b0, 32'd12345, 32'd11, 1'b0, 16, 1'b1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      s    = 1'($urandom);
      a    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0:       b = 32'd0;
        1:       b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(2, 15));
        3:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      run_div(s, a, b, 1'b0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
